gate_sensor_fsm: RTL and testbench

Upstream stage of the parking controller. It converts two raw, bouncy light-barrier sensors at the garage gate into single-cycle car_in / car_out pulses, which feed the parking counter's car_in / car_out inputs directly. Per-sensor synchronisation and debounce are followed by a direction-detection FSM with abort, illegal-sequence and timeout handling. The block runs in the divided (delayed) clock domain, the same clock as the parking counter.

---
 rtl/gate_sensor_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_gate_sensor_fsm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gate_sensor_fsm.sv
// ---------------------------------------------------------------------------
// gate_sensor_fsm
//
// Turns the two bouncy light barriers at the garage gate into single-cycle
// car_in / car_out pulses for the parking counter. Each sensor goes through a
// 2-flop synchroniser and a debounce counter. A direction FSM then tracks the
// order in which the barriers block and clear.
//
// Ports
//   clk         block clock (divided clock domain)
//   rst         asynchronous, active-high reset
//   sensor_a    raw outer barrier, 1 = beam blocked (async to clk)
//   sensor_b    raw inner barrier, 1 = beam blocked (async to clk)
//   car_in      one-cycle pulse per completed entry
//   car_out     one-cycle pulse per completed exit
//   fault       one-cycle pulse on illegal sequence or timeout
//   busy        high while the FSM is not in IDLE
//   sensors_db  debounced {a,b}
//
// State      | meaning
// -----------+--------------------------------------------------------
// IDLE       | gate clear, waiting for the first barrier
// IN_A       | entering: outer barrier blocked
// IN_AB      | entering: both barriers blocked
// IN_B       | entering: only the inner barrier still blocked
// OUT_B      | leaving: inner barrier blocked
// OUT_AB     | leaving: both barriers blocked
// OUT_A      | leaving: only the outer barrier still blocked
// WAIT_CLEAR | after a fault, wait for both beams to clear
// ---------------------------------------------------------------------------
module gate_sensor_fsm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic       car_in,
  output logic       car_out,
  output logic       fault,
  output logic       busy,
  output logic [1:0] sensors_db
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IN_A       = 3'd1,
    IN_AB      = 3'd2,
    IN_B       = 3'd3,
    OUT_B      = 3'd4,
    OUT_AB     = 3'd5,
    OUT_A      = 3'd6,
    WAIT_CLEAR = 3'd7
  } state_t;

  // The debounce counter commits on its last stable sample, so it never
  // actually holds DEBOUNCE_CYCLES and cannot wrap.
  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  // The FSM leaves on the edge where the timeout counter would reach
  // TIMEOUT_CYCLES-1. A timed state therefore lasts TIMEOUT_CYCLES-1 cycles.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 2);

  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] db;
  logic [7:0] db_cnt [2];

  state_t      state;
  state_t      state_nxt;
  logic [15:0] tmo_cnt;
  logic        timed;
  logic        in_nxt;
  logic        out_nxt;
  logic        fault_nxt;

  // Bit 1 is sensor a and bit 0 is sensor b throughout the block.
  assign raw        = {sensor_a, sensor_b};
  assign sensors_db = db;

  // Synchroniser and per-sensor debounce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      db        <= 2'b00;
      db_cnt[0] <= 8'd0;
      db_cnt[1] <= 8'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= 8'd0;
        end else if (db_cnt[i] >= DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= 8'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Direction FSM: next state and pulse decisions
  assign timed = (state != IDLE) && (state != WAIT_CLEAR);

  always_comb begin
    state_nxt = state;
    in_nxt    = 1'b0;
    out_nxt   = 1'b0;
    fault_nxt = 1'b0;

    case (state)
      IDLE: begin
        case (db)
          2'b10: state_nxt = IN_A;
          2'b01: state_nxt = OUT_B;
          2'b11: begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: ;
        endcase
      end
      IN_A: begin
        case (db)
          2'b11: state_nxt = IN_AB;
          2'b00: state_nxt = IDLE;
          2'b01: begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: ;
        endcase
      end
      IN_AB: begin
        case (db)
          2'b01: state_nxt = IN_B;
          2'b10: state_nxt = IN_A;
          2'b00: begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: ;
        endcase
      end
      IN_B: begin
        case (db)
          2'b00: begin state_nxt = IDLE; in_nxt = 1'b1; end
          2'b11: state_nxt = IN_AB;
          2'b10: begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: ;
        endcase
      end
      OUT_B: begin
        case (db)
          2'b11: state_nxt = OUT_AB;
          2'b00: state_nxt = IDLE;
          2'b10: begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: ;
        endcase
      end
      OUT_AB: begin
        case (db)
          2'b10: state_nxt = OUT_A;
          2'b01: state_nxt = OUT_B;
          2'b00: begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: ;
        endcase
      end
      OUT_A: begin
        case (db)
          2'b00: begin state_nxt = IDLE; out_nxt = 1'b1; end
          2'b11: state_nxt = OUT_AB;
          2'b01: begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: ;
        endcase
      end
      WAIT_CLEAR: begin
        if (db == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A legal transition in the same cycle takes precedence over the timeout.
    if (timed && (state_nxt == state) && (tmo_cnt == TO_LAST)) begin
      state_nxt = WAIT_CLEAR;
      fault_nxt = 1'b1;
    end
  end

  // State, timeout counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= 16'd0;
      car_in  <= 1'b0;
      car_out <= 1'b0;
      fault   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      car_in  <= in_nxt;
      car_out <= out_nxt;
      fault   <= fault_nxt;
      // Taken from the next state so that busy lines up with the state register.
      busy    <= (state_nxt != IDLE);
      if ((state_nxt != state) || !timed) begin
        tmo_cnt <= 16'd0;
      end else if (tmo_cnt != TO_LAST) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_sensor_fsm.sv
module tb_gate_sensor_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_a;
  logic       sensor_b;
  logic       car_in;
  logic       car_out;
  logic       fault;
  logic       busy;
  logic [1:0] sensors_db;

  localparam logic [1:0] EV_IN    = 2'd1;
  localparam logic [1:0] EV_OUT   = 2'd2;
  localparam logic [1:0] EV_FAULT = 2'd3;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  gate_sensor_fsm #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_a  (sensor_a),
    .sensor_b  (sensor_b),
    .car_in    (car_in),
    .car_out   (car_out),
    .fault     (fault),
    .busy      (busy),
    .sensors_db(sensors_db)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    cyc(n);
  endtask

  // Pulse monitor: every pulse pops the next expected event.
  always @(negedge clk) begin
    int         nhi;
    logic [1:0] code;
    if (!rst) begin
      nhi = int'(car_in) + int'(car_out) + int'(fault);
      if (nhi != 0) begin
        check("pulse_onehot", nhi, 1);
        code = car_in ? EV_IN : (car_out ? EV_OUT : EV_FAULT);
        if (exp_q.size() == 0) check("pulse_unexpected", {30'd0, code}, 0);
        else                   check("pulse_kind", {30'd0, code}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int k;
    int cnt;
    rst      = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    #12;
    check("reset_outputs", {27'd0, car_in, car_out, fault, busy, sensors_db}, 0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(3);
    check("idle_outputs", {27'd0, car_in, car_out, fault, busy, sensors_db}, 0);

    // Entry
    exp_q.push_back(EV_IN);
    drive(1'b1, 1'b0, 10);
    check("entry_db_10", sensors_db, 2'b10);
    check("entry_busy_a", busy, 1);
    drive(1'b1, 1'b1, 10);
    check("entry_db_11", sensors_db, 2'b11);
    drive(1'b0, 1'b1, 10);
    check("entry_busy_b", busy, 1);
    drive(1'b0, 1'b0, 10);
    check("entry_busy_end", busy, 0);
    check("entry_drain", exp_q.size(), 0);

    // Exit
    exp_q.push_back(EV_OUT);
    drive(1'b0, 1'b1, 10);
    check("exit_db_01", sensors_db, 2'b01);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 10);
    check("exit_busy_a", busy, 1);
    drive(1'b0, 1'b0, 10);
    check("exit_busy_end", busy, 0);
    check("exit_drain", exp_q.size(), 0);

    // Glitch rejection and abort
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 10);
    check("glitch3_db", sensors_db, 2'b00);
    check("glitch3_busy", busy, 0);
    sensor_a = 1'b1;
    cyc(5);
    check("glitch5_db_pre", sensors_db, 2'b00);
    sensor_a = 1'b0;
    cyc(1);
    check("glitch5_db_rise", sensors_db, 2'b10);
    cyc(1);
    check("glitch5_busy", busy, 1);
    drive(1'b0, 1'b0, 12);
    check("glitch5_abort_busy", busy, 0);
    check("glitch5_db_end", sensors_db, 2'b00);

    // Reversal then abort
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 10);
    check("rev_busy", busy, 1);
    drive(1'b0, 1'b0, 10);
    check("rev_busy_end", busy, 0);
    check("rev_drain", exp_q.size(), 0);

    // Illegal simultaneous change
    exp_q.push_back(EV_FAULT);
    drive(1'b1, 1'b1, 10);
    check("illegal_busy", busy, 1);
    check("illegal_drain", exp_q.size(), 0);
    drive(1'b1, 1'b0, 10);
    check("waitclear_hold", busy, 1);
    drive(1'b0, 1'b0, 10);
    check("waitclear_exit", busy, 0);

    // Timeout in IN_A
    exp_q.push_back(EV_FAULT);
    sensor_a = 1'b1;
    k = 0;
    while (!busy && k < 20) begin cyc(1); k++; end
    check("to_busy_seen", busy, 1);
    cnt = 0;
    while (!fault && cnt < 100) begin cyc(1); cnt++; end
    check("timeout_len", cnt, 63);
    cyc(16);
    check("timeout_waitclear", busy, 1);
    drive(1'b0, 1'b0, 12);
    check("timeout_busy_end", busy, 0);
    check("timeout_drain", exp_q.size(), 0);

    // Async reset in IN_AB
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    check("rst_pre_busy", busy, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rst_async_outputs", {27'd0, car_in, car_out, fault, busy, sensors_db}, 0);
    sensor_a = 1'b0;
    sensor_b = 1'b1;
    cyc(2);
    rst = 1'b0;
    drive(1'b0, 1'b1, 10);
    check("rst_after_db", sensors_db, 2'b01);
    check("rst_after_busy", busy, 1);
    drive(1'b0, 1'b0, 12);
    check("rst_after_idle", busy, 0);
    check("final_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
